alu_result_stage: RTL and testbench

- Sits directly downstream of the ALU and consumes one ALU result per issue.
- Latches the ALU flags into an architectural flags register and writes the data result to the register file over a req/ack handshake.
- Resolves jump opcodes into a one-cycle PC-load pulse.
- Keeps a retired-operation counter for debug/perf.

---
 rtl/alu_result_stage_pkg.sv | 64 ++++++
 rtl/alu_result_stage_if.sv | 38 +++
 rtl/alu_result_stage_jump_opcode_decode.sv | 26 ++
 rtl/alu_result_stage.sv | 133 +++++++++++++
 tb/tb_alu_result_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared opcode list, flag bit positions, FSM encoding and default widths for the ALU result stage.
package alu_result_stage_pkg;

    localparam int DATA_LEN_DEF       = 16;
    localparam int INSTR_LEN_DEF      = 8;
    localparam int REG_ADDR_LEN_DEF   = 3;
    localparam int RETIRE_CNT_LEN_DEF = 16;

    localparam int OPCODE_W = 8;

    localparam int FLAG_C = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_S = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_BRANCH = 2'd2
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 8'h00;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_ADC  = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_SBB  = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_AND  = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_OR   = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 8'h08;
    localparam logic [OPCODE_W-1:0] OP_INC  = 8'h09;
    localparam logic [OPCODE_W-1:0] OP_DEC  = 8'h0A;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 8'h0B;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 8'h0C;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 8'h0D;
    localparam logic [OPCODE_W-1:0] OP_TEST = 8'h10;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 8'h11;
    localparam logic [OPCODE_W-1:0] OP_SETC = 8'h12;
    localparam logic [OPCODE_W-1:0] OP_CLC  = 8'h13;
    localparam logic [OPCODE_W-1:0] OP_JA   = 8'h20;
    localparam logic [OPCODE_W-1:0] OP_JAE  = 8'h21;
    localparam logic [OPCODE_W-1:0] OP_JB   = 8'h22;
    localparam logic [OPCODE_W-1:0] OP_JBE  = 8'h23;
    localparam logic [OPCODE_W-1:0] OP_JC   = 8'h24;
    localparam logic [OPCODE_W-1:0] OP_JNC  = 8'h25;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 8'h26;
    localparam logic [OPCODE_W-1:0] OP_JNZ  = 8'h27;
    localparam logic [OPCODE_W-1:0] OP_JS   = 8'h28;
    localparam logic [OPCODE_W-1:0] OP_JNS  = 8'h29;
    localparam logic [OPCODE_W-1:0] OP_JO   = 8'h2A;
    localparam logic [OPCODE_W-1:0] OP_JNO  = 8'h2B;
    localparam logic [OPCODE_W-1:0] OP_JP   = 8'h2C;
    localparam logic [OPCODE_W-1:0] OP_JNP  = 8'h2D;
    localparam logic [OPCODE_W-1:0] OP_JPE  = 8'h2E;
    localparam logic [OPCODE_W-1:0] OP_JPO  = 8'h2F;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 8'h30;

    // Conditional jumps occupy one contiguous block; JMP sits just past it.
    function automatic logic is_jump_op(input logic [OPCODE_W-1:0] op);
        return ((op >= OP_JA) && (op <= OP_JPO)) || (op == OP_JMP);
    endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Issue bus from controller/ALU plus the register-file write handshake.
interface alu_result_stage_if #(
    parameter int dataLength        = 16,
    parameter int instructionLength = 8,
    parameter int regAddrLength     = 3
);
    logic                         issue_valid;
    logic                         issue_ready;
    logic [instructionLength-1:0] IR;
    logic [dataLength-1:0]        alu_out;
    logic                         alu_output_ready;
    logic                         alu_C;
    logic                         alu_Z;
    logic                         alu_S;
    logic                         alu_V;
    logic                         alu_P;
    logic [regAddrLength-1:0]     dest_addr;
    logic [dataLength-1:0]        jump_target;

    logic                         rf_we;
    logic [regAddrLength-1:0]     rf_waddr;
    logic [dataLength-1:0]        rf_wdata;
    logic                         rf_ack;

    modport master (
        output issue_valid, IR, alu_out, alu_output_ready,
        output alu_C, alu_Z, alu_S, alu_V, alu_P,
        output dest_addr, jump_target, rf_ack,
        input  issue_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  issue_valid, IR, alu_out, alu_output_ready,
        input  alu_C, alu_Z, alu_S, alu_V, alu_P,
        input  dest_addr, jump_target, rf_ack,
        output issue_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/alu_result_stage_jump_opcode_decode.sv
// Purpose: flags whether an opcode belongs to the jump set (JA..JPO, JMP).
// Latency: combinational.
// Backpressure: none.
module jump_opcode_decode
    import alu_result_stage_pkg::*;
#(
    parameter int instructionLength = INSTR_LEN_DEF
) (
    input  logic [instructionLength-1:0] IR,
    output logic                         is_jump
);

    logic [OPCODE_W-1:0] op;

    always_comb begin
        op = '0;
        for (int i = 0; i < OPCODE_W; i++) begin
            if (i < instructionLength) begin
                op[i] = IR[i];
            end
        end
    end

    assign is_jump = is_jump_op(op);

endmodule

// File: rtl/alu_result_stage.sv
// Purpose: retires ALU results (flags, reg write, jump); ALU_RESULT_BYPASS_EN adds a write-forward port.
// Latency: flags-only/not-taken 1 cycle, taken jump 2, write 2 + ack wait.
// Backpressure: issue_ready low in WRITE/BRANCH; WRITE holds until rf_ack, no timeout.
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int dataLength        = DATA_LEN_DEF,
    parameter int instructionLength = INSTR_LEN_DEF,
    parameter int regAddrLength     = REG_ADDR_LEN_DEF,
    parameter int retireCntLength   = RETIRE_CNT_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_result_stage_if.slave          bus,
    output logic [4:0]                 flags_q,
    output logic                       pc_load,
    output logic [dataLength-1:0]      pc_target,
    output logic [retireCntLength-1:0] retire_count
`ifdef ALU_RESULT_BYPASS_EN
    ,
    output logic                       bypass_valid,
    output logic [regAddrLength-1:0]   bypass_addr,
    output logic [dataLength-1:0]      bypass_data
`endif
);

    state_t                   state_q;
    state_t                   state_d;
    logic                     is_jump;
    logic                     taken;
    logic                     accept;
    logic                     retire;
    logic                     upd_flags;
    logic [4:0]               flags_in;
    logic [regAddrLength-1:0] waddr_q;
    logic [dataLength-1:0]    wdata_q;
    logic [dataLength-1:0]    target_q;

    jump_opcode_decode #(
        .instructionLength(instructionLength)
    ) u_jump_decode (
        .IR      (bus.IR),
        .is_jump (is_jump)
    );

    assign accept = (state_q == ST_IDLE) && bus.issue_valid;
    assign taken  = bus.alu_output_ready && (&bus.alu_out);

    always_comb begin
        flags_in         = '0;
        flags_in[FLAG_C] = bus.alu_C;
        flags_in[FLAG_Z] = bus.alu_Z;
        flags_in[FLAG_S] = bus.alu_S;
        flags_in[FLAG_V] = bus.alu_V;
        flags_in[FLAG_P] = bus.alu_P;
    end

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        upd_flags = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.issue_valid) begin
                    if (is_jump) begin
                        if (taken) begin
                            state_d = ST_BRANCH;
                        end else begin
                            retire = 1'b1;
                        end
                    end else begin
                        upd_flags = 1'b1;
                        if (bus.alu_output_ready) begin
                            state_d = ST_WRITE;
                        end else begin
                            retire = 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (bus.rf_ack) begin
                    state_d = ST_IDLE;
                    retire  = 1'b1;
                end
            end
            ST_BRANCH: begin
                state_d = ST_IDLE;
                retire  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            waddr_q      <= '0;
            wdata_q      <= '0;
            target_q     <= '0;
            flags_q      <= '0;
            retire_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                waddr_q  <= bus.dest_addr;
                wdata_q  <= bus.alu_out;
                target_q <= bus.jump_target;
            end
            if (upd_flags) begin
                flags_q <= flags_in;
            end
            if (retire) begin
                retire_count <= retire_count + 1'b1;
            end
        end
    end

    // Strobes decode straight from the state register so an async reset drops them at once.
    assign bus.issue_ready = (state_q == ST_IDLE);
    assign bus.rf_we       = (state_q == ST_WRITE);
    assign bus.rf_waddr    = waddr_q;
    assign bus.rf_wdata    = wdata_q;
    assign pc_load         = (state_q == ST_BRANCH);
    assign pc_target       = target_q;

`ifdef ALU_RESULT_BYPASS_EN
    assign bypass_valid = (state_q == ST_WRITE);
    assign bypass_addr  = bypass_valid ? waddr_q : '0;
    assign bypass_data  = bypass_valid ? wdata_q : '0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: writes, flag-only ops, jumps, reset mid-write, wrap.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  flags_q;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] retire_count;
`ifdef ALU_RESULT_BYPASS_EN
    logic        bypass_valid;
    logic [2:0]  bypass_addr;
    logic [15:0] bypass_data;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_result_stage_if #(.dataLength(16), .instructionLength(8), .regAddrLength(3)) bus ();

    alu_result_stage #(
        .dataLength(16), .instructionLength(8), .regAddrLength(3), .retireCntLength(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .flags_q      (flags_q),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .retire_count (retire_count)
`ifdef ALU_RESULT_BYPASS_EN
        ,
        .bypass_valid (bypass_valid),
        .bypass_addr  (bypass_addr),
        .bypass_data  (bypass_data)
`endif
    );

    task automatic idle_inputs();
        bus.issue_valid      = 1'b0;
        bus.IR               = OP_NOP;
        bus.alu_out          = 16'h0;
        bus.alu_output_ready = 1'b0;
        {bus.alu_C, bus.alu_Z, bus.alu_S, bus.alu_V, bus.alu_P} = 5'b0;
        bus.dest_addr        = 3'd0;
        bus.jump_target      = 16'h0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [15:0] res, input logic aor,
                         input logic [2:0] dest, input logic [15:0] tgt, input logic [4:0] fl);
        bus.issue_valid      = 1'b1;
        bus.IR               = op;
        bus.alu_out          = res;
        bus.alu_output_ready = aor;
        bus.dest_addr        = dest;
        bus.jump_target      = tgt;
        {bus.alu_C, bus.alu_Z, bus.alu_S, bus.alu_V, bus.alu_P} = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.rf_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b want 0", bus.rf_we); end
        checks++; if (bus.rf_waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %h want 0", bus.rf_waddr); end
        checks++; if (bus.rf_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", bus.rf_wdata); end
        checks++; if (flags_q !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 0", flags_q); end
        checks++; if (pc_load !== 1'b0 || pc_target !== 16'h0) begin errors++; $display("FAIL reset_pc got %b/%h want 0/0000", pc_load, pc_target); end
        checks++; if (retire_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0", retire_count); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.issue_ready); end
`ifdef ALU_RESULT_BYPASS_EN
        checks++; if ({bypass_valid, bypass_addr, bypass_data} !== 20'h0) begin errors++; $display("FAIL reset_bypass got %b/%h/%h want 0", bypass_valid, bypass_addr, bypass_data); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_add_write();
        int we_cnt = 0;
        @(negedge clk);
        issue(OP_ADD, 16'h00A5, 1'b1, 3'd3, 16'h0, 5'b10001);
        bus.rf_ack = 1'b0;
        @(negedge clk);
        idle_inputs();
        checks++; if (flags_q !== 5'b10001) begin errors++; $display("FAIL add_flags got %b want 10001", flags_q); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL add_ready got %b want 0", bus.issue_ready); end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.rf_we === 1'b1) begin
                we_cnt++;
                checks++; if (bus.rf_waddr !== 3'd3 || bus.rf_wdata !== 16'h00A5) begin errors++; $display("FAIL add_wbus got %h/%h want 3/00a5", bus.rf_waddr, bus.rf_wdata); end
            end
            bus.rf_ack = (bus.rf_we === 1'b1) && (we_cnt == 3);
        end
        checks++; if (we_cnt != 3) begin errors++; $display("FAIL add_we_cycles got %0d want 3", we_cnt); end
        checks++; if (retire_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d want 1", retire_count); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL add_ready_after got %b want 1", bus.issue_ready); end
    endtask

    task automatic test_cmp_flags();
        @(negedge clk);
        issue(OP_CMP, 16'h0, 1'b0, 3'd4, 16'h0, 5'b01000);
        @(negedge clk);
        idle_inputs();
        checks++; if (flags_q !== 5'b01000) begin errors++; $display("FAIL cmp_flags got %b want 01000", flags_q); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL cmp_rf_we got %b want 0", bus.rf_we); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL cmp_ready got %b want 1", bus.issue_ready); end
        checks++; if (retire_count !== 16'd2) begin errors++; $display("FAIL cmp_count got %0d want 2", retire_count); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL cmp_rf_we_late got %b want 0", bus.rf_we); end
    endtask

    task automatic test_jump();
        int pulses = 0;
        @(negedge clk);
        issue(OP_JZ, 16'hFFFF, 1'b1, 3'd1, 16'h0040, 5'b10110);
        @(negedge clk);
        idle_inputs();
        checks++; if (pc_load !== 1'b1 || pc_target !== 16'h0040) begin errors++; $display("FAIL jz_taken_pc got %b/%h want 1/0040", pc_load, pc_target); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL jz_taken_ready got %b want 0", bus.issue_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (pc_load === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL jz_taken_pulses got %0d want 1", pulses); end
        checks++; if (flags_q !== 5'b01000) begin errors++; $display("FAIL jz_taken_flags got %b want 01000", flags_q); end
        checks++; if (retire_count !== 16'd3) begin errors++; $display("FAIL jz_taken_count got %0d want 3", retire_count); end
        issue(OP_JZ, 16'h0000, 1'b1, 3'd1, 16'h0080, 5'b10110);
        @(negedge clk);
        idle_inputs();
        checks++; if (pc_load !== 1'b0 || bus.issue_ready !== 1'b1) begin errors++; $display("FAIL jz_not_taken got pc_load %b ready %b want 0/1", pc_load, bus.issue_ready); end
        checks++; if (retire_count !== 16'd4) begin errors++; $display("FAIL jz_not_taken_count got %0d want 4", retire_count); end
        checks++; if (flags_q !== 5'b01000) begin errors++; $display("FAIL jz_not_taken_flags got %b want 01000", flags_q); end
        @(negedge clk);
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL jz_not_taken_late got %b want 0", pc_load); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.rf_ack = 1'b1;
        issue(OP_CMP, 16'h0, 1'b0, 3'd0, 16'h0, 5'b00001);
        @(negedge clk);
        checks++; if (flags_q !== 5'b00001 || retire_count !== 16'd5) begin errors++; $display("FAIL b2b_cmp1 got %b/%0d want 00001/5", flags_q, retire_count); end
        issue(OP_CMP, 16'h0, 1'b0, 3'd0, 16'h0, 5'b00100);
        @(negedge clk);
        checks++; if (flags_q !== 5'b00100 || retire_count !== 16'd6) begin errors++; $display("FAIL b2b_cmp2 got %b/%0d want 00100/6", flags_q, retire_count); end
        issue(OP_ADD, 16'h0BEE, 1'b1, 3'd6, 16'h0, 5'b00000);
        @(negedge clk);
        // Held issue of an unknown opcode must be ignored while WRITE is busy.
        issue(8'hEE, 16'h1111, 1'b1, 3'd2, 16'h0, 5'b00010);
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd6 || bus.rf_wdata !== 16'h0BEE) begin errors++; $display("FAIL b2b_write1 got %b/%h/%h want 1/6/0bee", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b want 0", bus.issue_ready); end
        @(negedge clk);
        checks++; if (bus.rf_we !== 1'b0 || retire_count !== 16'd7 || flags_q !== 5'b00000) begin errors++; $display("FAIL b2b_retire1 got %b/%0d/%b want 0/7/00000", bus.rf_we, retire_count, flags_q); end
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd2 || bus.rf_wdata !== 16'h1111) begin errors++; $display("FAIL b2b_write2 got %b/%h/%h want 1/2/1111", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        checks++; if (flags_q !== 5'b00010) begin errors++; $display("FAIL b2b_unknown_flags got %b want 00010", flags_q); end
        @(negedge clk);
        bus.rf_ack = 1'b0;
        checks++; if (bus.rf_we !== 1'b0 || retire_count !== 16'd8) begin errors++; $display("FAIL b2b_retire2 got %b/%0d want 0/8", bus.rf_we, retire_count); end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        bus.rf_ack = 1'b0;
        issue(OP_ADD, 16'h5A5A, 1'b1, 3'd7, 16'h1234, 5'b11111);
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", bus.rf_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b want 0", bus.rf_we); end
        checks++; if ({bus.rf_waddr, bus.rf_wdata, flags_q} !== 24'h0) begin errors++; $display("FAIL rst_mid_bus got %h/%h/%b want 0", bus.rf_waddr, bus.rf_wdata, flags_q); end
        checks++; if (pc_target !== 16'h0 || retire_count !== 16'h0 || bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_misc got %h/%0d/%b want 0/0/1", pc_target, retire_count, bus.issue_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.rf_ack = 1'b1;
        issue(OP_ADD, 16'h0042, 1'b1, 3'd1, 16'h0, 5'b00000);
        @(negedge clk);
        idle_inputs();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 3'd1 || bus.rf_wdata !== 16'h0042) begin errors++; $display("FAIL rst_mid_after got %b/%h/%h want 1/1/0042", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        @(negedge clk);
        bus.rf_ack = 1'b0;
        checks++; if (retire_count !== 16'd1) begin errors++; $display("FAIL rst_mid_count got %0d want 1", retire_count); end
    endtask

`ifdef ALU_RESULT_BYPASS_EN
    task automatic test_bypass();
        @(negedge clk);
        bus.rf_ack = 1'b0;
        issue(OP_ADD, 16'h1234, 1'b1, 3'd5, 16'h0, 5'b00000);
        @(negedge clk);
        idle_inputs();
        checks++; if (bypass_valid !== 1'b1 || bypass_addr !== 3'd5 || bypass_data !== 16'h1234) begin errors++; $display("FAIL bypass_write got %b/%h/%h want 1/5/1234", bypass_valid, bypass_addr, bypass_data); end
        bus.rf_ack = 1'b1;
        @(negedge clk);
        bus.rf_ack = 1'b0;
        checks++; if (bypass_valid !== 1'b0) begin errors++; $display("FAIL bypass_retire got %b want 0", bypass_valid); end
    endtask
`endif

    task automatic test_wrap();
        rst_n = 1'b0;
        idle_inputs();
        bus.rf_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_TEST, 16'h0, 1'b0, 3'd0, 16'h0, 5'b00000);
        repeat (65535) @(negedge clk);
        checks++; if (retire_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_full got %h want ffff", retire_count); end
        @(negedge clk);
        idle_inputs();
        checks++; if (retire_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", retire_count); end
    endtask

    initial begin
        test_reset();
        test_add_write();
        test_cmp_flags();
        test_jump();
        test_back_to_back();
        test_reset_mid_write();
`ifdef ALU_RESULT_BYPASS_EN
        test_bypass();
`endif
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
